// File: rtl/bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_alu_seq
// Description : Sequencer that runs a 32-bit ALU operation one bit per cycle
//               through an external 1-bit ALU slice, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctl,
    output logic        sl_a,
    output logic        sl_b,
    output logic        sl_ainvert,
    output logic        sl_bnegate,
    output logic        sl_cin,
    output logic        sl_set_less,
    output logic [1:0]  sl_op,
    input  logic        sl_result,
    input  logic        sl_cout,
    input  logic        sl_set,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    localparam logic [3:0] c_ctl_and = 4'b0000;
    localparam logic [3:0] c_ctl_or  = 4'b0001;
    localparam logic [3:0] c_ctl_add = 4'b0010;
    localparam logic [3:0] c_ctl_sub = 4'b0110;
    localparam logic [3:0] c_ctl_slt = 4'b0111;
    localparam logic [3:0] c_ctl_nor = 4'b1100;
    localparam logic [4:0] c_last_bit = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SLT_FIX = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_ctl;
    logic [4:0]  r_cnt;
    logic        r_carry;
    logic [30:0] r_shift;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_cin31;
    logic        r_cout31;
    logic        r_set31;

    logic        w_ainv;
    logic        w_bneg;
    logic [1:0]  w_op;
    logic        w_legal;
    logic        w_arith;
    logic        w_is_slt;
    logic        w_last;

    always_comb begin
        w_ainv  = 1'b0;
        w_bneg  = 1'b0;
        w_op    = 2'd0;
        w_legal = 1'b1;
        case (r_ctl)
            c_ctl_and: w_op = 2'd0;
            c_ctl_or:  w_op = 2'd1;
            c_ctl_add: w_op = 2'd2;
            c_ctl_sub: begin w_bneg = 1'b1; w_op = 2'd2; end
            c_ctl_slt: begin w_bneg = 1'b1; w_op = 2'd3; end
            c_ctl_nor: begin w_ainv = 1'b1; w_bneg = 1'b1; w_op = 2'd0; end
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_arith  = (r_ctl == c_ctl_add) || (r_ctl == c_ctl_sub);
    assign w_is_slt = (r_ctl == c_ctl_slt);
    assign w_last   = (r_cnt == c_last_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        sl_a         = 1'b0;
        sl_b         = 1'b0;
        sl_ainvert   = 1'b0;
        sl_bnegate   = 1'b0;
        sl_cin       = 1'b0;
        sl_set_less  = 1'b0;
        sl_op        = 2'd0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                // Illegal controls feed zeros so the AND pass yields zero.
                sl_a       = w_legal & r_a[r_cnt];
                sl_b       = w_legal & r_b[r_cnt];
                sl_ainvert = w_ainv;
                sl_bnegate = w_bneg;
                sl_op      = w_op;
                sl_cin     = (r_cnt == 5'd0) ? w_bneg : r_carry;
                if (w_last) begin
                    w_next_state = w_is_slt ? SLT_FIX : DONE;
                end
            end
            SLT_FIX: begin
                busy         = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_ctl      <= 4'd0;
            r_cnt      <= 5'd0;
            r_carry    <= 1'b0;
            r_shift    <= 31'd0;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_cin31    <= 1'b0;
            r_cout31   <= 1'b0;
            r_set31    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_ctl   <= alu_ctl;
            r_cnt   <= 5'd0;
            r_carry <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt   <= r_cnt + 5'd1;
            r_carry <= sl_cout;
            r_shift <= {sl_result, r_shift[30:1]};
            if (w_last) begin
                r_cin31  <= sl_cin;
                r_cout31 <= sl_cout;
                r_set31  <= sl_set;
                // The visible result only changes at completion; SLT waits a cycle.
                if (!w_is_slt) begin
                    r_result   <= {sl_result, r_shift};
                    r_overflow <= w_arith & (sl_cin ^ sl_cout);
                end
            end
        end else if (r_state == SLT_FIX) begin
            r_result   <= {r_shift, r_set31 ^ r_cin31 ^ r_cout31};
            r_overflow <= 1'b0;
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;
    assign zero     = (r_result == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_alu_seq
// Description : Scoreboard bench pairing the sequencer with a 1-bit ALU slice.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctl;
    logic        sl_a, sl_b, sl_ainvert, sl_bnegate, sl_cin, sl_set_less;
    logic [1:0]  sl_op;
    logic        sl_result, sl_cout, sl_set;
    logic        busy, done, zero, overflow;
    logic [31:0] result;

    bit_serial_alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
        .sl_a(sl_a), .sl_b(sl_b), .sl_ainvert(sl_ainvert), .sl_bnegate(sl_bnegate),
        .sl_cin(sl_cin), .sl_set_less(sl_set_less), .sl_op(sl_op),
        .sl_result(sl_result), .sl_cout(sl_cout), .sl_set(sl_set),
        .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // 1-bit ALU slice
    logic w_aa, w_bb, w_sum;
    always_comb begin
        w_aa      = sl_a ^ sl_ainvert;
        w_bb      = sl_b ^ sl_bnegate;
        w_sum     = w_aa ^ w_bb ^ sl_cin;
        sl_cout   = (w_aa & w_bb) | (w_aa & sl_cin) | (w_bb & sl_cin);
        sl_set    = w_sum;
        sl_result = 1'b0;
        case (sl_op)
            2'd0:    sl_result = w_aa & w_bb;
            2'd1:    sl_result = w_aa | w_bb;
            2'd2:    sl_result = w_sum;
            default: sl_result = sl_set_less;
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a done sampled after edge D is seen by the edge D+1, hence cyc+1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
                end else begin
                    e = q.pop_front();
                    check_eq("result",   result,           e.res);
                    check_eq("zero",     {31'd0, zero},     {31'd0, e.z});
                    check_eq("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    check_eq("latency",  cyc + 1 - e.acc,   e.lat);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input logic ez, input logic eov,
                         input int lat, input bit push);
        exp_t e;
        alu_ctl = ctl;
        a       = va;
        b       = vb;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        if (push) begin
            e.res = er; e.z = ez; e.ov = eov; e.lat = lat; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
        end
    endtask

    task automatic check_quiet(input string nm);
        check_eq({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({nm, "_done"}, {31'd0, done}, 32'd0);
        check_eq({nm, "_sl"}, {24'd0, sl_a, sl_b, sl_ainvert, sl_bnegate, sl_cin, sl_set_less, sl_op}, 32'd0);
        check_eq({nm, "_result"}, result, 32'd0);
        check_eq({nm, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; alu_ctl = 4'd0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_zero", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 33, 1'b1);
        wait_done("add_ovf");
        issue(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 33, 1'b1);
        wait_done("sub_zero");
        issue(4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 33, 1'b1);
        wait_done("sub_ovf");
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 34, 1'b1);
        wait_done("slt_true");
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 34, 1'b1);
        wait_done("slt_false");
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 33, 1'b1);
        wait_done("and");
        issue(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 33, 1'b1);
        wait_done("or");
        issue(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 33, 1'b1);
        wait_done("nor");
        issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 33, 1'b1);
        wait_done("illegal");

        // start during RUN bit 10 must be ignored
        issue(4'b0010, 32'h0000_0400, 32'd2, 32'h0000_0402, 1'b0, 1'b0, 33, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("bit10_sl_a", {31'd0, sl_a}, 32'd1);
        check_eq("bit10_sl_b", {31'd0, sl_b}, 32'd0);
        a = 32'h1234_5678; b = 32'h1111_1111; alu_ctl = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");

        // back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        issue(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 33, 1'b1);
        wait_done("b2b_first");
        issue(4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 33, 1'b1);
        wait_done("b2b_second");

        // reset at RUN bit 16 aborts without a done pulse
        @(negedge clk);
        issue(4'b0010, 32'h0000_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 33, 1'b0);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_quiet("abort");
        repeat (40) @(negedge clk);
        issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 33, 1'b1);
        wait_done("after_reset");

        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
